// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed multiply / divide unit for the execute stage.
// One operation takes WIDTH+1 cycles from the start edge to the ready strobe.
// Multiply uses radix-2 shift-add on operand magnitudes. Divide uses restoring
// division on magnitudes. Signs, overflow and divide-by-zero are applied when
// the result is registered.
module multdiv_iter #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ctrl_MULT,
  input  logic                    ctrl_DIV,
  input  logic                    ctrl_cancel,
  input  logic signed [WIDTH-1:0] data_operandA,
  input  logic signed [WIDTH-1:0] data_operandB,
  output logic        [WIDTH-1:0] data_result,
  output logic                    data_exception,
  output logic                    data_resultRDY,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               start, start_div, step, finish;
  logic               is_div, neg, div_zero;
  logic [WIDTH-1:0]   m;       // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0]   hi;      // product high half (mul) or remainder (div)
  logic [WIDTH-1:0]   lo;      // multiplier bits (mul) or dividend/quotient (div)
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_r, div_trial;

  // Magnitude of a two's-complement value; MIN maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return v[WIDTH-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  // Apply the product sign and flag products that do not fit in WIDTH bits.
  function automatic logic [WIDTH:0] mul_finalize(input logic [2*WIDTH-1:0] mag,
                                                  input logic neg_in);
    logic signed [2*WIDTH-1:0] p;
    logic                      ovf;
    p   = neg_in ? -$signed(mag) : $signed(mag);
    ovf = (p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}});
    return {ovf, p[WIDTH-1:0]};
  endfunction

  // Apply the quotient sign; divide-by-zero yields 0, MIN/-1 yields MIN.
  function automatic logic [WIDTH:0] div_finalize(input logic [WIDTH-1:0] q,
                                                  input logic neg_in,
                                                  input logic zero_in);
    logic signed [WIDTH-1:0] s;
    logic                    ovf;
    s   = neg_in ? -$signed(q) : $signed(q);
    ovf = !neg_in && q[WIDTH-1];
    if (zero_in) return {1'b1, {WIDTH{1'b0}}};
    return {ovf, $unsigned(s)};
  endfunction

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: cancel, then multiply start, then divide start, then sequencing.
  always_comb begin
    state_nxt = state;
    if (ctrl_cancel)    state_nxt = S_IDLE;
    else if (ctrl_MULT) state_nxt = S_MUL;
    else if (ctrl_DIV)  state_nxt = S_DIV;
    else begin
      case (state)
        S_MUL, S_DIV: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = S_DONE;
        S_DONE:       state_nxt = S_IDLE;
        default:      state_nxt = S_IDLE;
      endcase
    end
  end

  // Control strobes decoded from state and inputs.
  always_comb begin
    start     = !ctrl_cancel && (ctrl_MULT || ctrl_DIV);
    start_div = !ctrl_MULT && ctrl_DIV;
    step      = !ctrl_cancel && !start && (state == S_MUL || state == S_DIV);
    finish    = !ctrl_cancel && (state == S_DONE);
  end

  // Iteration counter: cleared on start, advanced on each iteration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (start) cnt <= '0;
    else if (step)  cnt <= cnt + CNT_W'(1);
  end

  // One shift-add step and one restoring-division step.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_r     = {hi, lo[WIDTH-1]};
    div_trial = div_r - {1'b0, m};
  end

  // Datapath registers: operand capture on start, one iteration per step.
  always_ff @(posedge clock) begin
    if (start) begin
      is_div   <= start_div;
      neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == '0);
      hi       <= '0;
      m        <= start_div ? magnitude(data_operandB) : magnitude(data_operandA);
      lo       <= start_div ? magnitude(data_operandA) : magnitude(data_operandB);
    end else if (step) begin
      if (state == S_DIV) begin
        if (!div_trial[WIDTH]) begin
          hi <= div_trial[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= div_r[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

  // Registered outputs: result/exception on completion, strobe and busy flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= finish;
      busy           <= (state_nxt != S_IDLE);
      if (finish) begin
        if (is_div) {data_exception, data_result} <= div_finalize(lo, neg, div_zero);
        else        {data_exception, data_result} <= mul_finalize({hi, lo}, neg);
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Bench for multdiv_iter: a 32-bit and an 8-bit instance, driven with a
// table of directed vectors plus sequences for restart, cancel, back-to-back
// and asynchronous reset.
module tb_multdiv_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cancel = 1'b0;
  logic        mult32 = 1'b0, div32 = 1'b0, mult8 = 1'b0, div8 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [31:0] res32;
  logic [7:0]  res8;
  logic        exc32, exc8, rdy32, rdy8, busy32, busy8;
  logic        tsel = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  multdiv_iter #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .ctrl_MULT(mult32), .ctrl_DIV(div32),
    .ctrl_cancel(cancel), .data_operandA(a32), .data_operandB(b32),
    .data_result(res32), .data_exception(exc32), .data_resultRDY(rdy32),
    .busy(busy32));

  multdiv_iter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .ctrl_MULT(mult8), .ctrl_DIV(div8),
    .ctrl_cancel(cancel), .data_operandA(a8), .data_operandB(b8),
    .data_result(res8), .data_exception(exc8), .data_resultRDY(rdy8),
    .busy(busy8));

  wire [31:0] s_res  = tsel ? {24'd0, res8} : res32;
  wire        s_exc  = tsel ? exc8  : exc32;
  wire        s_rdy  = tsel ? rdy8  : rdy32;
  wire        s_busy = tsel ? busy8 : busy32;

  typedef struct {
    bit          sel;     // 1 = 8-bit instance
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a start pulse; called at a negedge.
  task automatic start_op(input bit sel, input bit d, input logic [31:0] a, input logic [31:0] b);
    tsel = sel;
    if (sel) begin
      mult8 = !d; div8 = d; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      mult32 = !d; div32 = d; a32 = a; b32 = b;
    end
  endtask

  task automatic clear_ctrl();
    mult32 = 1'b0; div32 = 1'b0; mult8 = 1'b0; div8 = 1'b0;
  endtask

  // After start_op: pass the start edge, then sample once per cycle for
  // samples s = 0..maxs (sample s follows edge E_s). Ends on a negedge.
  task automatic watch(input int maxs, output int lat, output int rdy_n, output int busy_n,
                       output logic [31:0] res, output logic exc);
    lat = -1; rdy_n = 0; busy_n = 0; res = 'x; exc = 1'bx;
    @(negedge clock);
    clear_ctrl();
    for (int s = 0; s <= maxs; s++) begin
      if (s_busy) busy_n++;
      if (s_rdy) begin
        if (rdy_n == 0) begin
          lat = s; res = s_res; exc = s_exc;
        end
        rdy_n++;
      end
      if (s < maxs) @(negedge clock);
    end
  endtask

  int          lat, rdy_n, busy_n, pre_rdy, w;
  logic [31:0] res;
  logic        exc;
  string       tag;

  initial begin
    vecs[0]  = '{0, 0, 32'd7,          -32'sd6,      32'hFFFF_FFD6, 0};
    vecs[1]  = '{0, 1, -32'sd100,      32'd7,        32'hFFFF_FFF2, 0};
    vecs[2]  = '{0, 1, 32'd5,          32'd0,        32'h0,         1};
    vecs[3]  = '{0, 0, 32'h4000_0000,  32'd4,        32'h0,         1};
    vecs[4]  = '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[5]  = '{0, 0, 32'h7FFF_FFFF,  32'd2,        32'hFFFF_FFFE, 1};
    vecs[6]  = '{0, 0, 32'h8000_0000,  32'd1,        32'h8000_0000, 0};
    vecs[7]  = '{0, 1, 32'd7,          -32'sd2,      32'hFFFF_FFFD, 0};
    vecs[8]  = '{0, 1, -32'sd7,        -32'sd2,      32'd3,         0};
    vecs[9]  = '{0, 1, 32'd0,          32'd5,        32'd0,         0};
    vecs[10] = '{0, 0, 32'd0,          -32'sd1,      32'd0,         0};
    vecs[11] = '{0, 0, 32'h0001_0000,  32'h0001_0000, 32'd0,        1};
    vecs[12] = '{0, 0, -32'sd65536,    32'd32768,    32'h8000_0000, 0};
    vecs[13] = '{0, 1, 32'd100,        32'd9,        32'd11,        0};
    vecs[14] = '{1, 1, 32'h80,         32'hFF,       32'h80,        1};
    vecs[15] = '{1, 0, 32'hFD,         32'h05,       32'hF1,        0};
    vecs[16] = '{1, 1, 32'h7F,         32'hFF,       32'h81,        0};
    vecs[17] = '{1, 0, 32'h10,         32'h08,       32'h80,        1};
    vecs[18] = '{1, 1, 32'h80,         32'h02,       32'hC0,        0};

    // Reset values while reset is held.
    #2;
    check("reset_result32", res32, 32'h0);
    check("reset_exc32",    {31'd0, exc32}, 32'h0);
    check("reset_rdy32",    {31'd0, rdy32}, 32'h0);
    check("reset_busy32",   {31'd0, busy32}, 32'h0);
    check("reset_busy8",    {31'd0, busy8}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      w = vecs[i].sel ? 8 : 32;
      start_op(vecs[i].sel, vecs[i].is_div, vecs[i].a, vecs[i].b);
      watch(w + 4, lat, rdy_n, busy_n, res, exc);
      tag = $sformatf("v%0d", i);
      check({tag, "_latency"}, lat, w + 1);
      check({tag, "_rdy_count"}, rdy_n, 1);
      check({tag, "_busy_cycles"}, busy_n, w + 1);
      check({tag, "_result"}, res, vecs[i].res);
      check({tag, "_exception"}, {31'd0, exc}, {31'd0, vecs[i].exc});
    end

    // Back-to-back: new divide started on the RDY cycle of a multiply.
    start_op(0, 0, 32'd7, -32'sd6);
    watch(33, lat, rdy_n, busy_n, res, exc);
    check("b2b_first_latency", lat, 33);
    check("b2b_first_result", res, 32'hFFFF_FFD6);
    start_op(0, 1, -32'sd100, 32'd7);
    watch(37, lat, rdy_n, busy_n, res, exc);
    check("b2b_second_latency", lat, 33);
    check("b2b_second_rdy_count", rdy_n, 1);
    check("b2b_second_result", res, 32'hFFFF_FFF2);

    // Restart: multiply discarded by a divide ten cycles later.
    start_op(0, 0, 32'd3, 32'd4);
    pre_rdy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k == 0) clear_ctrl();
      if (rdy32) pre_rdy++;
    end
    start_op(0, 1, 32'd100, 32'd9);
    watch(37, lat, rdy_n, busy_n, res, exc);
    check("restart_no_mul_rdy", pre_rdy, 0);
    check("restart_latency", lat, 33);
    check("restart_rdy_count", rdy_n, 1);
    check("restart_result", res, 32'd11);

    // Cancel five cycles into a multiply.
    start_op(0, 0, 32'd3, 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k == 0) clear_ctrl();
    end
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    check("cancel_busy_drop", {31'd0, busy32}, 32'h0);
    pre_rdy = 0;
    for (int k = 0; k < 40; k++) begin
      if (rdy32) pre_rdy++;
      @(negedge clock);
    end
    check("cancel_no_rdy", pre_rdy, 0);
    check("cancel_result_kept", res32, 32'd11);
    check("cancel_exc_kept", {31'd0, exc32}, 32'h0);

    // Asynchronous reset five cycles into a multiply.
    start_op(0, 0, 32'd3, 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k == 0) clear_ctrl();
    end
    reset = 1'b1;
    #1;
    check("async_reset_result", res32, 32'h0);
    check("async_reset_busy", {31'd0, busy32}, 32'h0);
    check("async_reset_rdy", {31'd0, rdy32}, 32'h0);
    check("async_reset_exc", {31'd0, exc32}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    pre_rdy = 0;
    w = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (rdy32) pre_rdy++;
      if (busy32) w++;
    end
    check("post_reset_no_rdy", pre_rdy, 0);
    check("post_reset_idle", w, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
